i2s_capture_ctrl: RTL and testbench

//  Sequences I2S microphone capture. Generates word-select (ws_out), counts bit slots,
//  and shifts sd_in into left/right samples. Delivers each stereo frame on a valid/ready

---
 rtl/i2s_capture_ctrl_if.sv | 21 ++
 rtl/i2s_capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_capture_ctrl_if.sv
// Stereo sample delivery channel between the I2S capture controller and the
// downstream audio FIFO/DSP: one frame per valid&&ready transfer.
interface i2s_capture_ctrl_if #(
    parameter int unsigned DATA_W = 24
);
    logic [2*DATA_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_capture_ctrl.sv
// I2S microphone capture sequencer: ws generation, bit-slot counting, L/R shift-in
// and frame delivery on valid/ready. Macro I2S_CAPTURE_STATS_EN adds frame/drop counters.
module i2s_capture_ctrl #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned SLOT_W = 32
) (
    input  logic               i2s_clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               sd_in,
    output logic               ws_out,
    i2s_capture_ctrl_if.master sample_if,
    output logic               overflow,
    input  logic               clear_ovf,
`ifdef I2S_CAPTURE_STATS_EN
    output logic [15:0]        frame_cnt,
    output logic [7:0]         ovf_cnt,
`endif
    output logic               busy
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned CTR_W   = $clog2(FRAME_W);

    localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(FRAME_W - 1);
    localparam logic [CTR_W-1:0] WS_START  = CTR_W'(SLOT_W);
    localparam logic [CTR_W-1:0] L_FIRST   = CTR_W'(1);
    localparam logic [CTR_W-1:0] L_LAST    = CTR_W'(DATA_W);
    localparam logic [CTR_W-1:0] R_FIRST   = CTR_W'(SLOT_W + 1);
    localparam logic [CTR_W-1:0] R_PENULT  = CTR_W'(SLOT_W + DATA_W - 1);
    localparam logic [CTR_W-1:0] R_LAST    = CTR_W'(SLOT_W + DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t              state_q,     state_d;
    logic [CTR_W-1:0]    bit_ctr_q,   bit_ctr_d;
    logic                ws_out_q,    ws_out_d;
    logic                busy_q,      busy_d;
    logic [DATA_W-1:0]   left_sr_q,   left_sr_d;
    logic [DATA_W-2:0]   right_sr_q,  right_sr_d;
    logic [2*DATA_W-1:0] data_q,      data_d;
    logic                valid_q,     valid_d;
    logic                overflow_q,  overflow_d;
`ifdef I2S_CAPTURE_STATS_EN
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [7:0]          ovf_cnt_q,   ovf_cnt_d;
`endif

    logic                frame_wrap;
    logic                capturing;
    logic                frame_done;
    logic                frame_load;
    logic                frame_drop;
    logic [2*DATA_W-1:0] new_frame;

    always_comb begin
        frame_wrap = (bit_ctr_q == CTR_LAST);
        capturing  = (state_q == ST_RUN) || (state_q == ST_STOP);
        frame_done = capturing && (bit_ctr_q == R_LAST);
        // The right LSB is still on sd_in at the completion edge, so it joins the frame directly.
        new_frame  = {left_sr_q, right_sr_q, sd_in};
        frame_load = frame_done && (!valid_q || sample_if.sample_ready);
        frame_drop = frame_done && valid_q && !sample_if.sample_ready;
    end

    always_comb begin
        state_d     = state_q;
        bit_ctr_d   = bit_ctr_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overflow_d  = overflow_q;
`ifdef I2S_CAPTURE_STATS_EN
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                bit_ctr_d = '0;
                if (enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                bit_ctr_d = frame_wrap ? '0 : bit_ctr_q + CTR_ONE;
                if (frame_wrap) begin
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                bit_ctr_d = frame_wrap ? '0 : bit_ctr_q + CTR_ONE;
                if (!enable) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                bit_ctr_d = frame_wrap ? '0 : bit_ctr_q + CTR_ONE;
                if (frame_wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_ctr_d = '0;
            end
        endcase

        if (state_q != ST_IDLE) begin
            if ((bit_ctr_q >= L_FIRST) && (bit_ctr_q <= L_LAST)) begin
                left_sr_d = {left_sr_q[DATA_W-2:0], sd_in};
            end
            if ((bit_ctr_q >= R_FIRST) && (bit_ctr_q <= R_PENULT)) begin
                right_sr_d = {right_sr_q[DATA_W-3:0], sd_in};
            end
        end

        if (frame_load) begin
            data_d  = new_frame;
            valid_d = 1'b1;
`ifdef I2S_CAPTURE_STATS_EN
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end else if (valid_q && sample_if.sample_ready) begin
            valid_d = 1'b0;
        end

        if (frame_drop) begin
            overflow_d = 1'b1;
`ifdef I2S_CAPTURE_STATS_EN
            if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
`endif
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    assign ws_out_d = (bit_ctr_d >= WS_START);
    assign busy_d   = (state_d != ST_IDLE);

    always_ff @(posedge i2s_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_ctr_q   <= '0;
            ws_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef I2S_CAPTURE_STATS_EN
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_ctr_q   <= bit_ctr_d;
            ws_out_q    <= ws_out_d;
            busy_q      <= busy_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
`ifdef I2S_CAPTURE_STATS_EN
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
`endif
        end
    end

    assign ws_out                 = ws_out_q;
    assign busy                   = busy_q;
    assign overflow               = overflow_q;
    assign sample_if.sample_data  = data_q;
    assign sample_if.sample_valid = valid_q;
`ifdef I2S_CAPTURE_STATS_EN
    assign frame_cnt              = frame_cnt_q;
    assign ovf_cnt                = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl: bench-side mic model driven by its own
// frame position; hand-computed expectations for delivery, overflow, stop and reset.
module tb_i2s_capture_ctrl;

    logic i2s_clk;
    logic reset_n;
    logic enable;
    logic sd_in;
    logic ws_out;
    logic overflow;
    logic clear_ovf;
    logic busy;
`ifdef I2S_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  ovf_cnt;
`endif

    i2s_capture_ctrl_if #(.DATA_W(24)) sif ();

    i2s_capture_ctrl #(
        .DATA_W(24),
        .SLOT_W(32)
    ) dut (
        .i2s_clk   (i2s_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .sd_in     (sd_in),
        .ws_out    (ws_out),
        .sample_if (sif),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
`ifdef I2S_CAPTURE_STATS_EN
        .frame_cnt (frame_cnt),
        .ovf_cnt   (ovf_cnt),
`endif
        .busy      (busy)
    );

    initial i2s_clk = 1'b0;
    always #5 i2s_clk = ~i2s_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pos      = 0;
    logic        active   = 1'b0;
    logic [23:0] cur_l    = '0;
    logic [23:0] cur_r    = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bits outside the capture windows are driven high so any stray shift is visible.
    function automatic logic mic_bit(input int unsigned c);
        if (c >= 1 && c <= 24)
            return cur_l[24 - c];
        else if (c >= 33 && c <= 56)
            return cur_r[56 - c];
        else
            return 1'b1;
    endfunction

    task automatic tick();
        sd_in = mic_bit(pos);
        @(posedge i2s_clk);
        #1;
        pos = (pos == 63) ? 0 : pos + 1;
        if (active)
            check_val("ws_out_slot", {63'd0, ws_out}, {63'd0, (pos >= 32)});
    endtask

    task automatic run_to(input int unsigned target);
        do tick(); while (pos != target);
    endtask

    task automatic start_arm();
        enable = 1'b1;
        pos    = 63;
        active = 1'b1;
        tick();
        check_val("busy_arm", {63'd0, busy}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        enable           = 1'b0;
        sd_in            = 1'b0;
        clear_ovf        = 1'b0;
        sif.sample_ready = 1'b0;
        repeat (3) @(posedge i2s_clk);
        #1;
        check_val("rst_ws",    {63'd0, ws_out}, 64'd0);
        check_val("rst_valid", {63'd0, sif.sample_valid}, 64'd0);
        check_val("rst_data",  {16'd0, sif.sample_data}, 64'd0);
        check_val("rst_ovf",   {63'd0, overflow}, 64'd0);
        check_val("rst_busy",  {63'd0, busy}, 64'd0);
        reset_n = 1'b1;
        @(posedge i2s_clk);
        #1;
        check_val("idle_busy", {63'd0, busy}, 64'd0);

        // Basic capture after a discarded wake-up frame
        cur_l = 24'hA5A5A5;
        cur_r = 24'h5A5A5A;
        sif.sample_ready = 1'b1;
        start_arm();
        run_to(57);
        check_val("arm_no_valid", {63'd0, sif.sample_valid}, 64'd0);
        run_to(0);
        run_to(56);
        check_val("f0_valid_c56", {63'd0, sif.sample_valid}, 64'd0);
        run_to(57);
        check_val("f0_valid_c57", {63'd0, sif.sample_valid}, 64'd1);
        check_val("f0_data", {16'd0, sif.sample_data}, 64'h0000_A5A5A5_5A5A5A);
        tick();
        check_val("f0_accepted", {63'd0, sif.sample_valid}, 64'd0);

        // Backpressure: overflow, clear, and clear coinciding with a drop
        sif.sample_ready = 1'b0;
        run_to(0);
        cur_l = 24'h123456;
        cur_r = 24'h654321;
        run_to(57);
        check_val("f1_valid", {63'd0, sif.sample_valid}, 64'd1);
        check_val("f1_data", {16'd0, sif.sample_data}, 64'h0000_123456_654321);
        check_val("f1_ovf", {63'd0, overflow}, 64'd0);
        run_to(0);
        cur_l = 24'h111111;
        cur_r = 24'h222222;
        run_to(57);
        check_val("f2_ovf", {63'd0, overflow}, 64'd1);
        check_val("f2_data_held", {16'd0, sif.sample_data}, 64'h0000_123456_654321);
        check_val("f2_valid", {63'd0, sif.sample_valid}, 64'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check_val("ovf_cleared", {63'd0, overflow}, 64'd0);
        run_to(0);
        cur_l = 24'h333333;
        cur_r = 24'h444444;
        run_to(56);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check_val("ovf_set_wins", {63'd0, overflow}, 64'd1);
        check_val("f3_data_held", {16'd0, sif.sample_data}, 64'h0000_123456_654321);
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check_val("ovf_cleared2", {63'd0, overflow}, 64'd0);

        // Ready arrives in the completion cycle
        run_to(0);
        cur_l = 24'h0F0F0F;
        cur_r = 24'hF0F0F0;
        run_to(56);
        check_val("f4_old_valid", {63'd0, sif.sample_valid}, 64'd1);
        sif.sample_ready = 1'b1;
        tick();
        check_val("f4_valid", {63'd0, sif.sample_valid}, 64'd1);
        check_val("f4_data", {16'd0, sif.sample_data}, 64'h0000_0F0F0F_F0F0F0);
        check_val("f4_ovf", {63'd0, overflow}, 64'd0);
        tick();
        check_val("f4_accepted", {63'd0, sif.sample_valid}, 64'd0);

        // Stop mid-frame: current frame still delivered, then idle
        run_to(0);
        cur_l = 24'hC3C3C3;
        cur_r = 24'h3C3C3C;
        run_to(10);
        enable = 1'b0;
        run_to(57);
        check_val("f5_valid", {63'd0, sif.sample_valid}, 64'd1);
        check_val("f5_data", {16'd0, sif.sample_data}, 64'h0000_C3C3C3_3C3C3C);
        check_val("stop_busy", {63'd0, busy}, 64'd1);
        run_to(63);
        check_val("stop_busy_c63", {63'd0, busy}, 64'd1);
        tick();
        active = 1'b0;
        check_val("stopped_busy", {63'd0, busy}, 64'd0);
        check_val("stopped_ws", {63'd0, ws_out}, 64'd0);
        repeat (3) tick();
        check_val("idle_hold_busy", {63'd0, busy}, 64'd0);
        check_val("idle_hold_ws", {63'd0, ws_out}, 64'd0);

        // Restart re-inserts the discard frame
        cur_l = 24'hBEEF01;
        cur_r = 24'h10FEEB;
        start_arm();
        run_to(57);
        check_val("rearm_no_valid", {63'd0, sif.sample_valid}, 64'd0);
        run_to(0);
        run_to(57);
        check_val("rearm_valid", {63'd0, sif.sample_valid}, 64'd1);
        check_val("rearm_data", {16'd0, sif.sample_data}, 64'h0000_BEEF01_10FEEB);
        sif.sample_ready = 1'b0;
        run_to(0);
        cur_l = 24'h2468AC;
        cur_r = 24'h13579B;
        run_to(57);
        check_val("drop3_ovf", {63'd0, overflow}, 64'd1);
        check_val("drop3_data", {16'd0, sif.sample_data}, 64'h0000_BEEF01_10FEEB);
`ifdef I2S_CAPTURE_STATS_EN
        check_val("stats_frames", {48'd0, frame_cnt}, 64'd5);
        check_val("stats_drops", {56'd0, ovf_cnt}, 64'd3);
`endif

        // Asynchronous reset mid-frame
        run_to(40);
        check_val("pre_rst_ws", {63'd0, ws_out}, 64'd1);
        check_val("pre_rst_busy", {63'd0, busy}, 64'd1);
        active  = 1'b0;
        reset_n = 1'b0;
        #2;
        check_val("arst_ws", {63'd0, ws_out}, 64'd0);
        check_val("arst_valid", {63'd0, sif.sample_valid}, 64'd0);
        check_val("arst_ovf", {63'd0, overflow}, 64'd0);
        check_val("arst_busy", {63'd0, busy}, 64'd0);
        check_val("arst_data", {16'd0, sif.sample_data}, 64'd0);
`ifdef I2S_CAPTURE_STATS_EN
        check_val("arst_frames", {48'd0, frame_cnt}, 64'd0);
        check_val("arst_drops", {56'd0, ovf_cnt}, 64'd0);
`endif
        repeat (2) @(posedge i2s_clk);
        #1;
        reset_n = 1'b1;
        sif.sample_ready = 1'b1;
        cur_l = 24'h9A9A9A;
        cur_r = 24'h6B6B6B;
        start_arm();
        run_to(57);
        check_val("post_rst_arm", {63'd0, sif.sample_valid}, 64'd0);
        run_to(0);
        run_to(57);
        check_val("post_rst_valid", {63'd0, sif.sample_valid}, 64'd1);
        check_val("post_rst_data", {16'd0, sif.sample_data}, 64'h0000_9A9A9A_6B6B6B);
`ifdef I2S_CAPTURE_STATS_EN
        check_val("post_rst_frames", {48'd0, frame_cnt}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
